asram16_arb: RTL and testbench

//  Sequencer/arbiter for the external 16-bit asynchronous SRAM. Shares one SRAM between
//  the CPU instruction-fetch port (16-bit words) and the data port (bytes), with

---
 rtl/asram16_arb.sv | 220 ++++++++++++++++++++++
 tb/tb_asram16_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/asram16_arb.sv
// -----------------------------------------------------------------------------
// asram16_arb
//
// Sequencer and two-port arbiter for an external 16-bit asynchronous SRAM. The
// CPU instruction-fetch port reads whole 16-bit words. The data port reads and
// writes single bytes. Each access lasts cfg_wait_i+1 cycles. Writes are
// followed by one recovery cycle that holds address and data on the pins
// (hold time) before the strobes are released.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   cfg_wait_i     extra SRAM access cycles, sampled at grant
//   i_req_i        instruction fetch request, held until i_ack_o
//   i_addr_i       instruction word address
//   i_rdata_o      fetched word, valid with i_ack_o, held until the next fetch
//   i_ack_o        one-cycle completion pulse, instruction port
//   d_req_i        data request, held until d_ack_o
//   d_we_i         1 = byte write, 0 = byte read
//   d_addr_i       data byte address, bit 0 selects the lane (1 = high byte)
//   d_wdata_i      write byte
//   d_rdata_o      read byte, valid with d_ack_o, held until the next data read
//   d_ack_o        one-cycle completion pulse, data port
//   ram_addr_o     SRAM word address
//   ram_cen_o      chip enable, active low
//   ram_oen_o      output enable, active low
//   ram_wen_o      write enable, active low
//   ram_wstrbn_o   byte strobes, active low, [1] = high byte
//   ram_dq_o       write data to the pad
//   ram_dq_oe_o    pad output enable, 1 = drive
//   ram_dq_i       read data from the pad
// -----------------------------------------------------------------------------
module asram16_arb #(
    parameter int unsigned RAM_AWIDTH = 17,
    parameter int unsigned WAIT_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WAIT_W-1:0]     cfg_wait_i,
    // Instruction port
    input  logic                  i_req_i,
    input  logic [RAM_AWIDTH-1:0] i_addr_i,
    output logic [15:0]           i_rdata_o,
    output logic                  i_ack_o,
    // Data port
    input  logic                  d_req_i,
    input  logic                  d_we_i,
    input  logic [RAM_AWIDTH:0]   d_addr_i,
    input  logic [7:0]            d_wdata_i,
    output logic [7:0]            d_rdata_o,
    output logic                  d_ack_o,
    // SRAM pins
    output logic [RAM_AWIDTH-1:0] ram_addr_o,
    output logic                  ram_cen_o,
    output logic                  ram_oen_o,
    output logic                  ram_wen_o,
    output logic [1:0]            ram_wstrbn_o,
    output logic [15:0]           ram_dq_o,
    output logic                  ram_dq_oe_o,
    input  logic [15:0]           ram_dq_i
);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StRecover
    } state_e;

    localparam logic PortInstr = 1'b0;
    localparam logic PortData  = 1'b1;

    state_e                  state_q;
    logic                    port_q;      // port owning the access in flight
    logic                    we_q;        // access in flight is a write
    logic                    lane_q;      // byte lane of a data access
    logic                    last_gnt_q;  // round-robin history
    logic [WAIT_W-1:0]       cnt_q;       // remaining ACCESS cycles minus one

    logic [RAM_AWIDTH-1:0]   ram_addr_q;
    logic                    ram_cen_q;
    logic                    ram_oen_q;
    logic                    ram_wen_q;
    logic [1:0]              ram_wstrbn_q;
    logic [15:0]             ram_dq_q;
    logic                    ram_dq_oe_q;
    logic [15:0]             i_rdata_q;
    logic [7:0]              d_rdata_q;
    logic                    i_ack_q;
    logic                    d_ack_q;

    // -------------------------------------------------------------------------
    // Grant decision. A port whose ack is on the bus this cycle still has its
    // old request asserted, so it is masked to avoid serving it twice.
    // -------------------------------------------------------------------------
    logic i_elig;
    logic d_elig;
    logic gnt_valid;
    logic gnt_data;

    always_comb begin
        i_elig    = i_req_i && !i_ack_q;
        d_elig    = d_req_i && !d_ack_q;
        gnt_valid = (state_q == StIdle) && (i_elig || d_elig);
        if (i_elig && d_elig) begin
            gnt_data = (last_gnt_q == PortInstr);
        end else begin
            gnt_data = d_elig;
        end
    end

    // -------------------------------------------------------------------------
    // Sequencer. Every pin and ack is a flop, set on the transition into the
    // state in which it must be visible.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            port_q       <= PortInstr;
            we_q         <= 1'b0;
            lane_q       <= 1'b0;
            last_gnt_q   <= PortInstr;
            cnt_q        <= '0;
            ram_addr_q   <= '0;
            ram_cen_q    <= 1'b1;
            ram_oen_q    <= 1'b1;
            ram_wen_q    <= 1'b1;
            ram_wstrbn_q <= 2'b11;
            ram_dq_q     <= '0;
            ram_dq_oe_q  <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            i_ack_q      <= 1'b0;
            d_ack_q      <= 1'b0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (gnt_valid) begin
                        state_q    <= StAccess;
                        port_q     <= gnt_data;
                        last_gnt_q <= gnt_data;
                        cnt_q      <= cfg_wait_i;
                        ram_cen_q  <= 1'b0;
                        if (gnt_data == PortData) begin
                            we_q         <= d_we_i;
                            lane_q       <= d_addr_i[0];
                            ram_addr_q   <= d_addr_i[RAM_AWIDTH:1];
                            ram_wstrbn_q <= d_addr_i[0] ? 2'b01 : 2'b10;
                            if (d_we_i) begin
                                ram_oen_q   <= 1'b1;
                                ram_wen_q   <= 1'b0;
                                ram_dq_oe_q <= 1'b1;
                                ram_dq_q    <= {d_wdata_i, d_wdata_i};
                            end else begin
                                ram_oen_q <= 1'b0;
                                ram_wen_q <= 1'b1;
                            end
                        end else begin
                            we_q         <= 1'b0;
                            lane_q       <= 1'b0;
                            ram_addr_q   <= i_addr_i;
                            ram_wstrbn_q <= 2'b00;
                            ram_oen_q    <= 1'b0;
                            ram_wen_q    <= 1'b1;
                        end
                    end
                end

                StAccess: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - WAIT_W'(1);
                    end else if (we_q) begin
                        // Release the write strobe but keep address, data and
                        // the pad driver up for one more cycle.
                        state_q   <= StRecover;
                        ram_wen_q <= 1'b1;
                    end else begin
                        state_q      <= StIdle;
                        ram_cen_q    <= 1'b1;
                        ram_oen_q    <= 1'b1;
                        ram_wstrbn_q <= 2'b11;
                        if (port_q == PortData) begin
                            d_rdata_q <= lane_q ? ram_dq_i[15:8] : ram_dq_i[7:0];
                            d_ack_q   <= 1'b1;
                        end else begin
                            i_rdata_q <= ram_dq_i;
                            i_ack_q   <= 1'b1;
                        end
                    end
                end

                StRecover: begin
                    state_q      <= StIdle;
                    ram_cen_q    <= 1'b1;
                    ram_wstrbn_q <= 2'b11;
                    ram_dq_oe_q  <= 1'b0;
                    d_ack_q      <= 1'b1;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ram_addr_o   = ram_addr_q;
    assign ram_cen_o    = ram_cen_q;
    assign ram_oen_o    = ram_oen_q;
    assign ram_wen_o    = ram_wen_q;
    assign ram_wstrbn_o = ram_wstrbn_q;
    assign ram_dq_o     = ram_dq_q;
    assign ram_dq_oe_o  = ram_dq_oe_q;
    assign i_rdata_o    = i_rdata_q;
    assign d_rdata_o    = d_rdata_q;
    assign i_ack_o      = i_ack_q;
    assign d_ack_o      = d_ack_q;

endmodule

// File: tb/tb_asram16_arb.sv
module tb_asram16_arb;

    logic        clk;
    logic        rst_n;
    logic [2:0]  cfg_wait_i;
    logic        i_req_i;
    logic [16:0] i_addr_i;
    logic [15:0] i_rdata_o;
    logic        i_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [17:0] d_addr_i;
    logic [7:0]  d_wdata_i;
    logic [7:0]  d_rdata_o;
    logic        d_ack_o;
    logic [16:0] ram_addr_o;
    logic        ram_cen_o;
    logic        ram_oen_o;
    logic        ram_wen_o;
    logic [1:0]  ram_wstrbn_o;
    logic [15:0] ram_dq_o;
    logic        ram_dq_oe_o;
    logic [15:0] ram_dq_i;

    asram16_arb #(
        .RAM_AWIDTH (17),
        .WAIT_W     (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_wait_i   (cfg_wait_i),
        .i_req_i      (i_req_i),
        .i_addr_i     (i_addr_i),
        .i_rdata_o    (i_rdata_o),
        .i_ack_o      (i_ack_o),
        .d_req_i      (d_req_i),
        .d_we_i       (d_we_i),
        .d_addr_i     (d_addr_i),
        .d_wdata_i    (d_wdata_i),
        .d_rdata_o    (d_rdata_o),
        .d_ack_o      (d_ack_o),
        .ram_addr_o   (ram_addr_o),
        .ram_cen_o    (ram_cen_o),
        .ram_oen_o    (ram_oen_o),
        .ram_wen_o    (ram_wen_o),
        .ram_wstrbn_o (ram_wstrbn_o),
        .ram_dq_o     (ram_dq_o),
        .ram_dq_oe_o  (ram_dq_oe_o),
        .ram_dq_i     (ram_dq_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Scoreboard of expected acks, in order.
    typedef struct {
        bit          port;   // 1 = data
        bit          rd;
        logic [15:0] rdata;
        int          cyc;    // cycle count at which the ack must be seen, <0 = any
    } sb_t;
    sb_t sb_q[$];

    always @(posedge clk) begin
        #1;
        if (rst_n && (i_ack_o || d_ack_o)) begin
            check("ack_overlap", {31'd0, i_ack_o && d_ack_o}, 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_ack", {30'd0, i_ack_o, d_ack_o}, 32'd0);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                check("ack_port", {31'd0, d_ack_o}, {31'd0, e.port});
                if (e.rd) begin
                    check("rdata", d_ack_o ? {24'd0, d_rdata_o} : {16'd0, i_rdata_o},
                          {16'd0, e.rdata});
                end
                if (e.cyc >= 0) check("ack_cycle", cyc, e.cyc);
            end
        end
    end

    typedef struct {
        bit          is_d;
        bit          we;
        logic [17:0] addr;
        logic [7:0]  wdata;
        logic [15:0] dqi;
        logic [2:0]  wt;
        bit          chg;       // drop cfg_wait to 0 mid-access
        logic [16:0] exp_addr;
        logic [1:0]  exp_strb;
        logic [15:0] exp_rdata;
    } vec_t;

    task automatic push_exp(input bit port, input bit rd, input logic [15:0] rdata,
                            input int at);
        sb_t e;
        e.port  = port;
        e.rd    = rd;
        e.rdata = rdata;
        e.cyc   = at;
        sb_q.push_back(e);
    endtask

    task automatic run_vec(input vec_t v);
        bit got;
        int w;
        w = int'(v.wt);
        @(negedge clk);
        cfg_wait_i = v.wt;
        ram_dq_i   = v.dqi;
        if (v.is_d) begin
            d_addr_i  = v.addr;
            d_we_i    = v.we;
            d_wdata_i = v.wdata;
        end else begin
            i_addr_i = v.addr[16:0];
        end
        push_exp(v.is_d, !v.we, v.exp_rdata, cyc + (v.we ? w + 3 : w + 2));
        if (v.is_d) d_req_i = 1'b1;
        else i_req_i = 1'b1;
        got = 1'b0;
        for (int k = 1; k <= 40 && !got; k++) begin
            @(posedge clk);
            #1;
            if (k == 2 && v.chg) cfg_wait_i = 3'd0;
            if (i_ack_o || d_ack_o) begin
                got = 1'b1;
            end else if (k <= w + 1) begin
                check("acc_cen", {31'd0, ram_cen_o}, 32'd0);
                check("acc_addr", {15'd0, ram_addr_o}, {15'd0, v.exp_addr});
                check("acc_strb", {30'd0, ram_wstrbn_o}, {30'd0, v.exp_strb});
                check("acc_oen", {31'd0, ram_oen_o}, {31'd0, v.we});
                check("acc_wen", {31'd0, ram_wen_o}, {31'd0, !v.we});
                check("acc_dqoe", {31'd0, ram_dq_oe_o}, {31'd0, v.we});
                if (v.we) check("acc_dq", {16'd0, ram_dq_o}, {16'd0, v.wdata, v.wdata});
            end else if (v.we && k == w + 2) begin
                check("rec_pins", {28'd0, ram_cen_o, ram_wen_o, ram_oen_o, ram_dq_oe_o},
                      32'b0111);
                check("rec_dq", {16'd0, ram_dq_o}, {16'd0, v.wdata, v.wdata});
            end
        end
        if (!got) check("ack_timeout", 32'd0, 32'd1);
        else check("idle_pins", {28'd0, ram_cen_o, ram_wen_o, ram_oen_o, ram_dq_oe_o},
                   32'b1110);
        @(negedge clk);
        i_req_i = 1'b0;
        d_req_i = 1'b0;
    endtask

    vec_t vecs[9];

    initial begin
        int nack;
        int base;
        bit d_done;
        bit i_done;

        rst_n      = 1'b0;
        cfg_wait_i = 3'd0;
        i_req_i    = 1'b0;
        i_addr_i   = '0;
        d_req_i    = 1'b0;
        d_we_i     = 1'b0;
        d_addr_i   = '0;
        d_wdata_i  = '0;
        ram_dq_i   = '0;

        //         is_d we  addr      wdata  dqi       wt  chg exp_addr   strb   rdata
        vecs[0] = '{1'b0, 1'b0, 18'h00123, 8'h00, 16'hA55A, 3'd0, 1'b0, 17'h00123, 2'b00, 16'hA55A};
        vecs[1] = '{1'b1, 1'b1, 18'h00247, 8'h3C, 16'h0000, 3'd0, 1'b0, 17'h00123, 2'b01, 16'h0000};
        vecs[2] = '{1'b1, 1'b1, 18'h00247, 8'h3C, 16'h0000, 3'd2, 1'b0, 17'h00123, 2'b01, 16'h0000};
        vecs[3] = '{1'b1, 1'b0, 18'h00246, 8'h00, 16'hBEEF, 3'd0, 1'b0, 17'h00123, 2'b10, 16'h00EF};
        vecs[4] = '{1'b1, 1'b0, 18'h00247, 8'h00, 16'hBEEF, 3'd1, 1'b0, 17'h00123, 2'b01, 16'h00BE};
        vecs[5] = '{1'b0, 1'b0, 18'h1FFFF, 8'h00, 16'h5AA5, 3'd3, 1'b0, 17'h1FFFF, 2'b00, 16'h5AA5};
        vecs[6] = '{1'b1, 1'b0, 18'h3FFFF, 8'h00, 16'hC3D4, 3'd0, 1'b0, 17'h1FFFF, 2'b01, 16'h00C3};
        vecs[7] = '{1'b1, 1'b0, 18'h00000, 8'h00, 16'h7788, 3'd7, 1'b1, 17'h00000, 2'b10, 16'h0088};
        vecs[8] = '{1'b0, 1'b0, 18'h00055, 8'h00, 16'h1357, 3'd0, 1'b0, 17'h00055, 2'b00, 16'h1357};

        // Reset state
        #12;
        check("rst_pins", {24'd0, ram_cen_o, ram_oen_o, ram_wen_o, ram_wstrbn_o, ram_dq_oe_o,
                           i_ack_o, d_ack_o}, 32'b1111_1000);
        check("rst_addr_dq", {ram_addr_o[15:0], ram_dq_o}, 32'd0);
        check("rst_rdata", {8'd0, i_rdata_o, d_rdata_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) run_vec(vecs[n]);
        check("d_rdata_hold", {24'd0, d_rdata_o}, 32'h88);

        // Both ports requesting continuously: D,I,D,I with wait 1.
        @(negedge clk);
        cfg_wait_i = 3'd1;
        ram_dq_i   = 16'h1234;
        i_addr_i   = 17'h00100;
        d_addr_i   = 18'h00200;
        d_we_i     = 1'b0;
        base       = cyc;
        push_exp(1'b1, 1'b1, 16'h0034, base + 3);
        push_exp(1'b0, 1'b1, 16'h1234, base + 6);
        push_exp(1'b1, 1'b1, 16'h0034, base + 9);
        push_exp(1'b0, 1'b1, 16'h1234, base + 12);
        i_req_i = 1'b1;
        d_req_i = 1'b1;
        nack = 0;
        for (int k = 0; k < 40 && nack < 4; k++) begin
            @(posedge clk);
            #1;
            if (i_ack_o || d_ack_o) nack++;
        end
        check("rr_acks", nack, 4);
        @(negedge clk);
        i_req_i = 1'b0;
        d_req_i = 1'b0;

        // Reset during a write access.
        @(negedge clk);
        cfg_wait_i = 3'd3;
        d_addr_i   = 18'h00010;
        d_we_i     = 1'b1;
        d_wdata_i  = 8'h5A;
        d_req_i    = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("pre_rst_wen", {31'd0, ram_wen_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("async_rst_pins", {29'd0, ram_wen_o, ram_cen_o, ram_dq_oe_o}, 32'b110);
        i_req_i  = 1'b1;
        i_addr_i = 17'h00077;
        ram_dq_i = 16'h0F0F;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        push_exp(1'b1, 1'b0, 16'h0000, base + 6);
        push_exp(1'b0, 1'b1, 16'h0F0F, base + 11);
        d_done = 1'b0;
        i_done = 1'b0;
        for (int k = 0; k < 40 && !(d_done && i_done); k++) begin
            @(posedge clk);
            #1;
            if (d_ack_o) d_done = 1'b1;
            if (i_ack_o) i_done = 1'b1;
            @(negedge clk);
            if (d_done) d_req_i = 1'b0;
            if (i_done) i_req_i = 1'b0;
        end
        check("post_rst_acks", {30'd0, d_done, i_done}, 32'b11);

        repeat (3) @(posedge clk);
        #2;
        check("sb_empty", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
